// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load-use stall detection, EX operand forwarding
// selects and writeback-to-ID bypass, tracked through shadow EX/MEM/WB slots.
module id_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_wr,
   input  logic             id_load,
   input  logic             flush,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             byp_a,
   output logic             byp_b,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       load;
   } slot_t;

   slot_t ex_r, mem_r, wb_r;
   slot_t ex_nxt_s;
   logic  issue_s;
   logic  ex_hit_rs_s, ex_hit_rt_s;
   logic  [1:0] fwd_a_nxt_s, fwd_b_nxt_s;

   // Register 0 is hard-wired zero, so it can never create a dependency.
   function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
      return s.valid & s.wr & (s.rd == r) & (r != 5'd0);
   endfunction

   // Youngest producer wins: EX/MEM result before MEM/WB result.
   function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                          input logic [4:0] r);
      logic [1:0] sel;
      if (writes_reg(ex_s, r)) begin
         sel = 2'b01;
      end else if (writes_reg(mem_s, r)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection, bypass, and next EX slot / forwarding selects.
   always_comb begin
      ex_hit_rs_s = 1'b0;
      ex_hit_rt_s = 1'b0;
      stall       = 1'b0;
      byp_a       = 1'b0;
      byp_b       = 1'b0;
      issue_s     = 1'b0;
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
      ex_nxt_s    = '0;

      ex_hit_rs_s = id_use_rs & writes_reg(ex_r, id_rs);
      ex_hit_rt_s = id_use_rt & writes_reg(ex_r, id_rt);

      if (id_valid && !flush && ex_r.load && (ex_hit_rs_s || ex_hit_rt_s)) begin
         stall = 1'b1;
      end else begin
         stall = 1'b0;
      end

      byp_a   = id_valid & id_use_rs & writes_reg(wb_r, id_rs);
      byp_b   = id_valid & id_use_rt & writes_reg(wb_r, id_rt);
      issue_s = id_valid & ~flush & ~stall;

      if (issue_s) begin
         ex_nxt_s.valid = 1'b1;
         ex_nxt_s.rd    = id_rd;
         ex_nxt_s.wr    = id_wr;
         ex_nxt_s.load  = id_load;
         fwd_a_nxt_s    = id_use_rs ? fwd_sel(ex_r, mem_r, id_rs) : 2'b00;
         fwd_b_nxt_s    = id_use_rt ? fwd_sel(ex_r, mem_r, id_rt) : 2'b00;
      end else begin
         ex_nxt_s    = '0;
         fwd_a_nxt_s = 2'b00;
         fwd_b_nxt_s = 2'b00;
      end
   end

   // Pipeline shadow slots, forwarding registers and saturating stall counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_r      <= '0;
         mem_r     <= '0;
         wb_r      <= '0;
         fwd_a     <= 2'b00;
         fwd_b     <= 2'b00;
         stall_cnt <= {CNT_W{1'b0}};
      end else begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         ex_r  <= ex_nxt_s;
         fwd_a <= fwd_a_nxt_s;
         fwd_b <= fwd_b_nxt_s;
         if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt <= stall_cnt;
         end
      end
   end

endmodule
